// File: rtl/word2byte_pkg.sv
// Shared constants and FSM encoding for the word/byte
// streaming blocks (dumper and assembler).
package word2byte_pkg;

  localparam int ADDR_W         = 10;
  localparam int DATA_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = ADDR_W + 1;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  localparam logic [CNT_W-1:0] MAX_WORDS =
    CNT_W'(1 << ADDR_W);
  localparam logic [IDX_W-1:0] LAST_BYTE =
    IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  function automatic logic [CNT_W-1:0] clamp_cnt(
    input logic [CNT_W-1:0] c
  );
    return (c > MAX_WORDS) ? MAX_WORDS : c;
  endfunction

endpackage

// File: rtl/word2byte.sv
// Dumps a block of memory words as a little-endian byte
// stream, borrowing the CPU memory port while busy.
module word2byte
  import word2byte_pkg::*;
(
  input  logic              clkMem,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [CNT_W-1:0]  wordCount,
  input  logic              abort,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [3:0]        weIn,
  input  logic              enIn,
  input  logic [DATA_W-1:0] memData,
  output logic [ADDR_W-1:0] addrOut,
  output logic [DATA_W-1:0] dataOut,
  output logic [3:0]        weOut,
  output logic              enOut,
  output logic [7:0]        txData,
  output logic              txValid,
  input  logic              txReady,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_rdAddr;
  logic [CNT_W-1:0]  r_remaining;
  logic [IDX_W-1:0]  r_byteIdx;
  logic [DATA_W-1:0] r_shift;
  logic              r_txValid;
  logic              r_busy;
  logic              r_done;

  logic w_acc;
  logic w_last;
  logic w_fsm_port;

  assign w_acc  = r_txValid & txReady;
  assign w_last = w_acc && (r_byteIdx == LAST_BYTE);
  // reset hands the port back to the CPU immediately
  assign w_fsm_port = r_busy & ~rst;

  assign txData  = r_shift[7:0];
  assign txValid = r_txValid;
  assign busy    = r_busy;
  assign done    = r_done;

  always_comb begin
    addrOut = addrIn;
    dataOut = dataIn;
    weOut   = weIn;
    enOut   = enIn;
    if (w_fsm_port) begin
      addrOut = r_rdAddr;
      dataOut = '0;
      weOut   = '0;
      enOut   = (r_state == S_READ);
    end
  end

  always_ff @(posedge clkMem) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rdAddr    <= '0;
      r_remaining <= '0;
      r_byteIdx   <= '0;
      r_shift     <= '0;
      r_txValid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (wordCount != '0) begin
              r_rdAddr    <= startAddr;
              r_remaining <= clamp_cnt(wordCount);
              r_state     <= S_READ;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_READ: begin
          if (abort) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_shift   <= memData;
            r_byteIdx <= '0;
            r_txValid <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_acc) begin
            r_shift   <= r_shift >> 8;
            r_byteIdx <= r_byteIdx + 1'b1;
          end
          if (w_last) begin
            r_remaining <= r_remaining - 1'b1;
            r_rdAddr    <= r_rdAddr + 1'b1;
            r_txValid   <= 1'b0;
            if (abort || r_remaining == CNT_W'(1)) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_READ;
            end
          end else if (abort) begin
            r_txValid <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word2byte.sv
// Directed bench for word2byte: table of dumps plus
// stall, abort, busy-start and mid-dump reset sequences.
`timescale 1ns/1ps
module tb_word2byte;

  logic        clkMem = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  startAddr;
  logic [10:0] wordCount;
  logic        abort;
  logic [9:0]  addrIn;
  logic [31:0] dataIn;
  logic [3:0]  weIn;
  logic        enIn;
  logic [31:0] memData;
  logic [9:0]  addrOut;
  logic [31:0] dataOut;
  logic [3:0]  weOut;
  logic        enOut;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic        busy;
  logic        done;

  word2byte dut (
    .clkMem(clkMem), .rst(rst), .start(start),
    .startAddr(startAddr), .wordCount(wordCount),
    .abort(abort), .addrIn(addrIn), .dataIn(dataIn),
    .weIn(weIn), .enIn(enIn), .memData(memData),
    .addrOut(addrOut), .dataOut(dataOut),
    .weOut(weOut), .enOut(enOut), .txData(txData),
    .txValid(txValid), .txReady(txReady),
    .busy(busy), .done(done)
  );

  always #5 clkMem = ~clkMem;

  logic [31:0] mem [0:1023];
  logic [9:0]  rdq [$];

  always @(posedge clkMem) begin
    if (enOut && weOut == 4'h0) memData <= mem[addrOut];
    if (!rst && busy && enOut && weOut == 4'h0)
      rdq.push_back(addrOut);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0]  sa;
    logic [10:0] wc;
    logic [63:0] bytes;
    int          nb;
    int          dk;
    int          nr;
    logic [9:0]  a0;
    logic [9:0]  a1;
  } vec_t;

  vec_t tbl [5];

  task automatic run_dump(
    input  logic [9:0]  sa,
    input  logic [10:0] wc,
    input  int          ab_k,
    input  int          st_k,
    input  bit          toggle,
    output int          nb,
    output logic [63:0] got,
    output int          first_k,
    output int          done_k,
    output int          unstable
  );
    logic [7:0] held;
    bit         hold;
    nb = 0; got = '0; first_k = -1; done_k = -1;
    unstable = 0; hold = 0; held = '0;
    rdq.delete();
    @(negedge clkMem);
    start = 1'b1; startAddr = sa; wordCount = wc;
    for (int k = 1; k < 8000; k++) begin
      @(negedge clkMem);
      start = (k == st_k);
      abort = (k == ab_k);
      if (k == ab_k) txReady = 1'b0;
      else if (toggle) txReady = k[0];
      else txReady = 1'b1;
      if (toggle && hold && (!txValid || txData !== held))
        unstable++;
      hold = txValid && !txReady;
      held = txData;
      if (txValid && first_k < 0) first_k = k;
      if (txValid && txReady) begin
        if (nb < 8) got[8*nb +: 8] = txData;
        nb++;
      end
      if (done) begin
        done_k = k;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    txReady = 1'b1;
  endtask

  int          nb, fk, dk, us;
  logic [63:0] got;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5]    = 32'h44332211;
    mem[1023] = 32'hDDCCBBAA;
    mem[0]    = 32'h87654321;
    mem[100]  = 32'h0F0E0D0C;
    mem[101]  = 32'h13121110;

    tbl[0] = '{10'd5, 11'd1, 64'h44332211,
               4, 7, 1, 10'd5, 10'd0};
    tbl[1] = '{10'd1023, 11'd2, 64'h87654321_DDCCBBAA,
               8, 13, 2, 10'd1023, 10'd0};
    tbl[2] = '{10'd100, 11'd2, 64'h13121110_0F0E0D0C,
               8, 13, 2, 10'd100, 10'd101};
    tbl[3] = '{10'd7, 11'd0, 64'h0,
               0, 1, 0, 10'd0, 10'd0};
    tbl[4] = '{10'd0, 11'd2047, 64'h00000000_87654321,
               4096, 6145, 1024, 10'd0, 10'd1};

    rst = 1'b1; start = 1'b0; startAddr = '0;
    wordCount = '0; abort = 1'b0; txReady = 1'b1;
    addrIn = 10'h155; dataIn = 32'hA5A5_5A5A;
    weIn = 4'h3; enIn = 1'b1;
    repeat (3) @(negedge clkMem);
    chk("rst txValid", 64'(txValid), 64'd0);
    chk("rst txData", 64'(txData), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst pass", {addrOut, dataOut, weOut, enOut},
        {10'h155, 32'hA5A5_5A5A, 4'h3, 1'b1});
    rst = 1'b0;
    addrIn = 10'h2AA; dataIn = 32'h0123_4567;
    weIn = 4'h0; enIn = 1'b0;
    #1;
    chk("idle pass", {addrOut, dataOut, weOut, enOut},
        {10'h2AA, 32'h0123_4567, 4'h0, 1'b0});
    @(negedge clkMem);

    for (int i = 0; i < 5; i++) begin
      run_dump(tbl[i].sa, tbl[i].wc, -1, -1, 1'b0,
               nb, got, fk, dk, us);
      chk($sformatf("v%0d nbytes", i), 64'(nb),
          64'(tbl[i].nb));
      chk($sformatf("v%0d bytes", i), got, tbl[i].bytes);
      chk($sformatf("v%0d done_k", i), 64'(dk),
          64'(tbl[i].dk));
      chk($sformatf("v%0d first_k", i), 64'(fk),
          (tbl[i].nb > 0) ? 64'd3 : 64'hFFFF_FFFF_FFFF_FFFF);
      chk($sformatf("v%0d nreads", i), 64'(rdq.size()),
          64'(tbl[i].nr));
      if (rdq.size() > 0 && tbl[i].nr > 0)
        chk($sformatf("v%0d addr0", i), 64'(rdq[0]),
            64'(tbl[i].a0));
      if (rdq.size() > 1 && tbl[i].nr > 1)
        chk($sformatf("v%0d addr1", i), 64'(rdq[1]),
            64'(tbl[i].a1));
      @(negedge clkMem);
      chk($sformatf("v%0d idle", i), 64'(busy), 64'd0);
    end

    // stalled transmitter
    run_dump(10'd100, 11'd2, -1, -1, 1'b1,
             nb, got, fk, dk, us);
    chk("stall nbytes", 64'(nb), 64'd8);
    chk("stall bytes", got, 64'h13121110_0F0E0D0C);
    chk("stall stable", 64'(us), 64'd0);
    @(negedge clkMem);

    // abort after two bytes
    run_dump(10'd5, 11'd1, 5, -1, 1'b0,
             nb, got, fk, dk, us);
    chk("abort nbytes", 64'(nb), 64'd2);
    chk("abort bytes", got, 64'h2211);
    chk("abort done_k", 64'(dk), 64'd6);
    chk("abort txValid", 64'(txValid), 64'd0);
    @(negedge clkMem);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort pass", {addrOut, dataOut, weOut, enOut},
        {10'h2AA, 32'h0123_4567, 4'h0, 1'b0});

    // start while busy is ignored
    run_dump(10'd5, 11'd1, -1, 2, 1'b0,
             nb, got, fk, dk, us);
    chk("busy start done_k", 64'(dk), 64'd7);
    chk("busy start nbytes", 64'(nb), 64'd4);
    @(negedge clkMem);
    chk("busy start idle", 64'(busy), 64'd0);
    repeat (2) @(negedge clkMem);
    chk("busy start nreads", 64'(rdq.size()), 64'd1);

    // reset in the middle of SEND
    @(negedge clkMem);
    start = 1'b1; startAddr = 10'd100; wordCount = 11'd2;
    repeat (4) begin
      @(negedge clkMem);
      start = 1'b0;
    end
    chk("mid txValid", 64'(txValid), 64'd1);
    rst = 1'b1; addrIn = 10'h200; dataIn = 32'hDEADBEEF;
    weIn = 4'hF; enIn = 1'b1;
    #1;
    chk("rst write pass", {addrOut, dataOut, weOut, enOut},
        {10'h200, 32'hDEADBEEF, 4'hF, 1'b1});
    @(negedge clkMem);
    chk("mid rst out", {txValid, txData, busy, done},
        {1'b0, 8'h00, 1'b0, 1'b0});
    rst = 1'b0; weIn = 4'h0; enIn = 1'b0;
    @(negedge clkMem);
    chk("mid rst nodone", {done, busy}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word2byte.md
WORD2BYTE -- requirements
Module: word2byte

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; clkMem is the only clock and rst is the reset.
REQ-002 clkMem  in  1  system/memory clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  one-cycle pulse; begins a dump when the block is idle.
REQ-005 startAddr  in  10  first word address, sampled on accepted start.
REQ-006 wordCount  in  11  number of words to dump (0..1024), sampled on accepted start.
REQ-007 abort  in  1  level; terminates an active dump.
REQ-008 addrIn/dataIn/weIn/enIn  in  10/32/4/1  CPU memory port, passed through when not busy.
REQ-009 memData  in  32  memory read data, valid one cycle after enOut=1, weOut=0.
REQ-010 addrOut/dataOut/weOut/enOut  out  10/32/4/1  muxed memory port.
REQ-011 txData  out  8  byte stream to the transmitter.
REQ-012 txValid  out  1  txData valid; txReady  in  1  transmitter accepts.
REQ-013 busy  out  1  dump in progress; done  out  1  one-cycle pulse at dump end or abort.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WAIT, SEND, DONE.
REQ-015 IDLE: start=1 with wordCount>0 -> READ, latch startAddr into rdAddr and wordCount into remaining; start with wordCount=0 -> DONE; start ignored in every state other than IDLE.
REQ-016 READ (one cycle): addrOut=rdAddr, enOut=1, weOut=0, dataOut=0 -> WAIT.
REQ-017 WAIT (one cycle): capture memData into a 32-bit shift register, byteIdx=0 -> SEND.
REQ-018 SEND: txValid=1, txData=shiftReg[7:0]; on txValid&txReady shift the register right 8 bits and increment byteIdx.
REQ-019 Byte order SHALL be little-endian: bits [7:0] first, [31:24] last.
REQ-020 On the 4th accepted byte: remaining decrements; rdAddr increments modulo 1024 (1023 wraps to 0); -> READ if remaining becomes nonzero, else -> DONE.
REQ-021 txData SHALL remain stable while txValid=1 and txReady=0.
REQ-022 DONE (one cycle): done=1 -> IDLE.
REQ-023 Latency: start at cycle N -> READ at N+1 -> first txValid at N+3; with txReady tied high, each word takes 6 cycles.
REQ-024 busy=1 in READ, WAIT, SEND, and DONE; while busy=1, the memory port is driven by the FSM and CPU inputs are ignored. In SEND and DONE: enOut=0, weOut=0, addrOut=rdAddr, dataOut=0.
REQ-025 busy=0: addrOut=addrIn, dataOut=dataIn, weOut=weIn, enOut=enIn, combinationally.
REQ-026 abort=1 in READ, WAIT, or SEND -> DONE next cycle; txValid drops that cycle; a byte accepted in the same cycle as abort counts as transferred.
REQ-027 A wordCount value above 1024 SHALL be treated as 1024.
REQ-028 weOut SHALL never be nonzero while busy=1.

Reset
REQ-029 rst=1 SHALL force IDLE, rdAddr=0, remaining=0, byteIdx=0, shiftReg=0, txValid=0, txData=0, busy=0, done=0, regardless of state.
REQ-030 While rst=1, the memory port SHALL pass through the CPU port.
REQ-031 rst asserted mid-dump SHALL drop txValid on the next edge with no done pulse.

Structure
REQ-032 FSM state encoding and constants (ADDR_W=10, DATA_W=32, BYTES_PER_WORD=4) SHALL live in a shared package, also used by the byte-to-word assembler.
REQ-033 Single module; no sub-module. The port mux is combinational logic within it.

Verification
REQ-034 Memory[5]=0x44332211, start with startAddr=5, wordCount=1, txReady=1 -> bytes 0x11,0x22,0x33,0x44 on cycles N+3..N+6; done at N+7.
REQ-035 startAddr=1023, wordCount=2 -> reads at addrOut=1023 then 0; 8 bytes in order.
REQ-036 txReady toggling every other cycle -> txData held stable while stalled; no byte lost or duplicated.
REQ-037 abort after the 2nd byte -> txValid=0 next cycle, done pulse, busy=0, port returns to CPU passthrough.
REQ-038 start with wordCount=0 -> no READ, done on the next cycle; start during busy -> ignored.
REQ-039 rst mid-SEND -> all outputs at reset values next cycle; a CPU write (weIn=4'hF) passes through the port.
